// File: rtl/mb32_arb.sv
// mb32_arb -- two-requester arbiter in front of the mb32 single-port memory.
//
// Requester 0 is instruction fetch and requester 1 is data/stack access.
// Both share one 32-bit-wide SPRAM block. Each cycle at most one requester
// is granted, and its command goes straight through to the memory in that
// same cycle.
//
// Arbitration rules:
//   - Round-robin on ties.
//   - An optional lock holds ownership across several cycles, for example
//     for a read-modify-write.
//   - The lock is broken after MAX_LOCK cycles, so the other side is never
//     starved for longer than that.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   rN_req/we/ai/vi/bmsk  requester N command (held until granted)
//   rN_lock               keep ownership after this access
//   rN_gnt                command accepted this cycle (combinational)
//   rN_rvld               read data for requester N valid on rd_vo
//   rd_vo                 read data, straight from m_vo
//   m_we/ai/vi/bmsk       memory command outputs
//   m_vo                  memory read data (one cycle after the address)
`timescale 1ns/1ps
module mb32_arb #(
    parameter int DSZ      = 32,
    parameter int ASZ      = 15,
    parameter int MAX_LOCK = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           r0_req,
    input  logic           r0_we,
    input  logic [ASZ-1:0] r0_ai,
    input  logic [DSZ-1:0] r0_vi,
    input  logic [3:0]     r0_bmsk,
    input  logic           r0_lock,
    input  logic           r1_req,
    input  logic           r1_we,
    input  logic [ASZ-1:0] r1_ai,
    input  logic [DSZ-1:0] r1_vi,
    input  logic [3:0]     r1_bmsk,
    input  logic           r1_lock,
    output logic           r0_gnt,
    output logic           r1_gnt,
    output logic           r0_rvld,
    output logic           r1_rvld,
    output logic [DSZ-1:0] rd_vo,
    output logic           m_we,
    output logic [ASZ-1:0] m_ai,
    output logic [DSZ-1:0] m_vi,
    output logic [3:0]     m_bmsk,
    input  logic [DSZ-1:0] m_vo
);

    typedef enum logic [1:0] {FREE, OWN0, OWN1} state_t;

    localparam logic [7:0] MAX_CNT = 8'(MAX_LOCK);

    state_t         state_q, state_d;
    logic           last_q, last_d;
    logic [7:0]     lockCnt_q, lockCnt_d;
    logic [7:0]     cntInc;
    logic           rvld0_q, rvld1_q;
    logic [ASZ-1:0] aiHold_q;
    logic [DSZ-1:0] viHold_q;
    logic           gnt0Raw, gnt1Raw;
    logic           gnt0, gnt1;

    // Grant decision. Ties in FREE go to the requester that did not win last.
    // Grants are gated by rst_n so that nothing reaches the memory while the
    // reset is applied. In particular, m_we drops low asynchronously.
    always_comb begin
        gnt0Raw = 1'b0;
        gnt1Raw = 1'b0;
        case (state_q)
            FREE: begin
                if (r0_req && r1_req) begin
                    gnt0Raw = last_q;
                    gnt1Raw = ~last_q;
                end else begin
                    gnt0Raw = r0_req;
                    gnt1Raw = r1_req;
                end
            end
            OWN0:    gnt0Raw = r0_req;
            OWN1:    gnt1Raw = r1_req;
            default: ;
        endcase
    end

    assign gnt0   = gnt0Raw & rst_n;
    assign gnt1   = gnt1Raw & rst_n;
    assign r0_gnt = gnt0;
    assign r1_gnt = gnt1;

    // Memory command mux. When nothing is granted, the address and data
    // outputs hold the last values they drove.
    always_comb begin
        m_we   = 1'b0;
        m_bmsk = 4'b0000;
        m_ai   = aiHold_q;
        m_vi   = viHold_q;
        if (gnt0) begin
            m_we   = r0_we;
            m_bmsk = r0_bmsk;
            m_ai   = r0_ai;
            m_vi   = r0_vi;
        end else if (gnt1) begin
            m_we   = r1_we;
            m_bmsk = r1_bmsk;
            m_ai   = r1_ai;
            m_vi   = r1_vi;
        end
    end

    assign rd_vo   = m_vo;
    assign r0_rvld = rvld0_q;
    assign r1_rvld = rvld1_q;

    // Lock bookkeeping. Every cycle spent in an owned state counts toward
    // the lock budget, including idle cycles. The counter saturates rather
    // than wrapping. When the budget is used up, ownership is dropped and
    // last points at the old owner, so the other requester wins the next tie.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        lockCnt_d = lockCnt_q;
        cntInc    = (lockCnt_q >= MAX_CNT) ? MAX_CNT : lockCnt_q + 8'd1;
        if (gnt0) begin
            last_d = 1'b0;
        end else if (gnt1) begin
            last_d = 1'b1;
        end
        case (state_q)
            FREE: begin
                if (gnt0 && r0_lock) begin
                    state_d   = OWN0;
                    lockCnt_d = 8'd1;
                end else if (gnt1 && r1_lock) begin
                    state_d   = OWN1;
                    lockCnt_d = 8'd1;
                end
            end
            OWN0: begin
                if (gnt0 && !r0_lock) begin
                    state_d   = FREE;
                    lockCnt_d = 8'd0;
                end else begin
                    lockCnt_d = cntInc;
                end
            end
            OWN1: begin
                if (gnt1 && !r1_lock) begin
                    state_d   = FREE;
                    lockCnt_d = 8'd0;
                end else begin
                    lockCnt_d = cntInc;
                end
            end
            default: begin
                state_d   = FREE;
                lockCnt_d = 8'd0;
            end
        endcase
        if (state_d != FREE && lockCnt_d >= MAX_CNT) begin
            last_d    = (state_d == OWN1);
            state_d   = FREE;
            lockCnt_d = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FREE;
            last_q    <= 1'b1;
            lockCnt_q <= 8'd0;
            rvld0_q   <= 1'b0;
            rvld1_q   <= 1'b0;
            aiHold_q  <= '0;
            viHold_q  <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            lockCnt_q <= lockCnt_d;
            rvld0_q   <= gnt0 & ~r0_we;
            rvld1_q   <= gnt1 & ~r1_we;
            if (gnt0 || gnt1) begin
                aiHold_q <= m_ai;
                viHold_q <= m_vi;
            end
        end
    end

endmodule

// File: tb/tb_mb32_arb.sv
// Testbench for mb32_arb: behavioural SPRAM plus a reference model of the
// arbitration, lock and read-return rules.
`timescale 1ns/1ps
module tb_mb32_arb;
    localparam int DSZ      = 32;
    localparam int ASZ      = 15;
    localparam int MAX_LOCK = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic           r0_req = 0, r0_we = 0, r0_lock = 0;
    logic [ASZ-1:0] r0_ai = '0;
    logic [DSZ-1:0] r0_vi = '0;
    logic [3:0]     r0_bmsk = '0;
    logic           r1_req = 0, r1_we = 0, r1_lock = 0;
    logic [ASZ-1:0] r1_ai = '0;
    logic [DSZ-1:0] r1_vi = '0;
    logic [3:0]     r1_bmsk = '0;
    logic           r0_gnt, r1_gnt, r0_rvld, r1_rvld, m_we;
    logic [DSZ-1:0] rd_vo, m_vi;
    logic [DSZ-1:0] m_vo = '0;
    logic [ASZ-1:0] m_ai;
    logic [3:0]     m_bmsk;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int             ownerM;   // -1 free, else owning requester
    int             runM;     // locked cycles so far
    int             lastM;    // last granted requester
    int             pendRd;   // requester expecting rvld now, -1 none
    logic [31:0]    pendData;
    logic [ASZ-1:0] aiHoldM;
    logic [31:0]    viHoldM;

    logic [31:0] physMem [0:32767];
    logic [31:0] refMem  [0:32767];

    always #5 clk = ~clk;

    mb32_arb #(.DSZ(DSZ), .ASZ(ASZ), .MAX_LOCK(MAX_LOCK)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_req(r0_req), .r0_we(r0_we), .r0_ai(r0_ai), .r0_vi(r0_vi),
        .r0_bmsk(r0_bmsk), .r0_lock(r0_lock),
        .r1_req(r1_req), .r1_we(r1_we), .r1_ai(r1_ai), .r1_vi(r1_vi),
        .r1_bmsk(r1_bmsk), .r1_lock(r1_lock),
        .r0_gnt(r0_gnt), .r1_gnt(r1_gnt), .r0_rvld(r0_rvld), .r1_rvld(r1_rvld),
        .rd_vo(rd_vo), .m_we(m_we), .m_ai(m_ai), .m_vi(m_vi), .m_bmsk(m_bmsk),
        .m_vo(m_vo)
    );

    // Behavioural single-port RAM: byte-masked write, registered read.
    always @(posedge clk) begin
        if (m_we) begin
            for (int b = 0; b < 4; b++) begin
                if (m_bmsk[b]) physMem[m_ai][8*b +: 8] <= m_vi[8*b +: 8];
            end
        end
        m_vo <= physMem[m_ai];
    end

    function automatic logic [31:0] initWord(input int a);
        return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A_0000;
    endfunction

    // Arbitration rule: the owner alone; otherwise the single requester,
    // or on a tie the one that did not win last.
    function automatic int expGrant();
        if (ownerM == 0) return r0_req ? 0 : -1;
        if (ownerM == 1) return r1_req ? 1 : -1;
        if (r0_req && r1_req) return (lastM == 1) ? 0 : 1;
        if (r0_req) return 0;
        if (r1_req) return 1;
        return -1;
    endfunction

    task automatic modelReset();
        ownerM  = -1;
        runM    = 0;
        lastM   = 1;
        pendRd  = -1;
        aiHoldM = '0;
        viHoldM = '0;
    endtask

    // Advance one clock edge and apply the access granted this cycle to the model.
    task automatic advance(input int eg);
        logic           we, lk;
        logic [ASZ-1:0] ai;
        logic [31:0]    vi;
        logic [3:0]     bm;
        @(posedge clk);
        pendRd = -1;
        if (eg >= 0) begin
            we = (eg == 0) ? r0_we   : r1_we;
            lk = (eg == 0) ? r0_lock : r1_lock;
            ai = (eg == 0) ? r0_ai   : r1_ai;
            vi = (eg == 0) ? r0_vi   : r1_vi;
            bm = (eg == 0) ? r0_bmsk : r1_bmsk;
            if (!we) begin
                pendRd   = eg;
                pendData = refMem[ai];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (bm[b]) refMem[ai][8*b +: 8] = vi[8*b +: 8];
            end
            aiHoldM = ai;
            viHoldM = vi;
            lastM   = eg;
            if (ownerM == -1) begin
                if (lk) begin
                    ownerM = eg;
                    runM   = 1;
                end
            end else if (!lk) begin
                ownerM = -1;
                runM   = 0;
            end else begin
                runM++;
            end
        end else if (ownerM != -1) begin
            runM++;
        end
        if (ownerM != -1 && runM >= MAX_LOCK) begin
            lastM  = ownerM;
            ownerM = -1;
            runM   = 0;
        end
        #1;
    endtask

    task automatic idle();
        r0_req = 0;
        r1_req = 0;
        @(negedge clk);
        advance(expGrant());
    endtask

    task automatic test_reset();
        rst_n = 0;
        modelReset();
        #12;
        checks++;
        if ({r0_gnt, r1_gnt, r0_rvld, r1_rvld, m_we, m_bmsk} !== 9'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl got %b%b%b%b%b %b want all zero",
                     r0_gnt, r1_gnt, r0_rvld, r1_rvld, m_we, m_bmsk);
        end
        checks++;
        if (m_ai !== '0 || m_vi !== '0) begin
            errors++;
            $display("[TB] FAIL reset_bus m_ai=%h m_vi=%h want 0", m_ai, m_vi);
        end
        r0_req = 1;
        r0_we = 1;
        r0_bmsk = 4'hF;
        #3;
        checks++;
        if (m_we !== 1'b0 || r0_gnt !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_req m_we=%b r0_gnt=%b want 0", m_we, r0_gnt);
        end
        r0_req = 0;
        r0_we = 0;
        r0_bmsk = 0;
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_first_read();
        int eg;
        r0_req = 1;
        r0_we = 0;
        r0_ai = 15'h0010;
        r0_lock = 0;
        @(negedge clk);
        eg = expGrant();
        checks++;
        if (r0_gnt !== 1'b1 || r1_gnt !== 1'b0 || m_ai !== 15'h0010) begin
            errors++;
            $display("[TB] FAIL first_gnt r0_gnt=%b r1_gnt=%b m_ai=%h want 1 0 0010",
                     r0_gnt, r1_gnt, m_ai);
        end
        advance(eg);
        r0_req = 0;
        checks++;
        if (r0_rvld !== 1'b1 || r1_rvld !== 1'b0 || rd_vo !== initWord(16)) begin
            errors++;
            $display("[TB] FAIL first_rvld rvld=%b%b rd_vo=%h want 10 %h",
                     r0_rvld, r1_rvld, rd_vo, initWord(16));
        end
    endtask

    task automatic test_round_robin();
        int eg;
        // A lone r1 access first makes requester 0 the winner of the next tie.
        r1_req = 1;
        r1_we = 0;
        r1_ai = 15'h0100;
        r1_lock = 0;
        @(negedge clk);
        advance(expGrant());
        for (int i = 0; i < 6; i++) begin
            r0_req = 1;
            r0_we = 0;
            r0_lock = 0;
            r0_ai = ASZ'($urandom_range(0, 32767));
            r1_req = 1;
            r1_ai = ASZ'($urandom_range(0, 32767));
            @(negedge clk);
            eg = expGrant();
            checks++;
            if ({r0_gnt, r1_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                errors++;
                $display("[TB] FAIL rr_gnt[%0d] got %b%b want %s", i, r0_gnt, r1_gnt,
                         (i % 2 == 0) ? "10" : "01");
            end
            advance(eg);
            checks++;
            if ({r0_rvld, r1_rvld} !== ((i % 2 == 0) ? 2'b10 : 2'b01) || rd_vo !== pendData) begin
                errors++;
                $display("[TB] FAIL rr_rvld[%0d] rvld=%b%b rd_vo=%h want data %h",
                         i, r0_rvld, r1_rvld, rd_vo, pendData);
            end
        end
        idle();
    endtask

    task automatic test_write_top();
        logic [31:0] expWord;
        expWord = {refMem[15'h7FFF][31:16], 16'hBEEF};
        r1_req = 1;
        r1_we = 1;
        r1_ai = 15'h7FFF;
        r1_vi = 32'hDEADBEEF;
        r1_bmsk = 4'b0011;
        r1_lock = 0;
        @(negedge clk);
        checks++;
        if (r1_gnt !== 1'b1 || m_we !== 1'b1 || m_bmsk !== 4'b0011 ||
            m_ai !== 15'h7FFF || m_vi !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL wr_cmd gnt=%b we=%b bmsk=%b ai=%h vi=%h",
                     r1_gnt, m_we, m_bmsk, m_ai, m_vi);
        end
        advance(expGrant());
        checks++;
        if (r1_rvld !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wr_no_rvld r1_rvld=%b want 0", r1_rvld);
        end
        r1_we = 0;
        @(negedge clk);
        advance(expGrant());
        r1_req = 0;
        checks++;
        if (r1_rvld !== 1'b1 || rd_vo !== expWord) begin
            errors++;
            $display("[TB] FAIL wr_readback rvld=%b rd_vo=%h want 1 %h", r1_rvld, rd_vo, expWord);
        end
        @(negedge clk);
        checks++;
        if (m_we !== 1'b0 || m_bmsk !== 4'b0 || m_ai !== 15'h7FFF || r1_gnt !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_hold we=%b bmsk=%b ai=%h gnt=%b want 0 0 7fff 0",
                     m_we, m_bmsk, m_ai, r1_gnt);
        end
        advance(expGrant());
    endtask

    task automatic test_locked_rmw();
        logic [31:0] rdWord;
        r1_req = 1;
        r1_we = 0;
        r1_ai = 15'h0200;
        r1_lock = 0;
        r0_req = 1;
        r0_we = 0;
        r0_ai = 15'h0042;
        r0_lock = 1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            checks++;
            if (r1_gnt !== (c == 4) || r0_gnt !== (c == 1 || c == 3)) begin
                errors++;
                $display("[TB] FAIL rmw_gnt[%0d] r0_gnt=%b r1_gnt=%b", c, r0_gnt, r1_gnt);
            end
            advance(expGrant());
            if (c == 1) begin
                rdWord = rd_vo;
                checks++;
                if (r0_rvld !== 1'b1 || rd_vo !== pendData) begin
                    errors++;
                    $display("[TB] FAIL rmw_read rvld=%b rd_vo=%h want 1 %h", r0_rvld, rd_vo, pendData);
                end
                r0_req = 0;
            end else if (c == 2) begin
                r0_req = 1;
                r0_we = 1;
                r0_vi = rdWord + 32'd1;
                r0_bmsk = 4'hF;
                r0_lock = 0;
            end else begin
                r0_req = 0;
                r0_we = 0;
            end
        end
        r1_req = 0;
        checks++;
        if (refMem[15'h0042] !== physMem[15'h0042] || refMem[15'h0042] !== initWord(32'h42) + 32'd1) begin
            errors++;
            $display("[TB] FAIL rmw_mem got %h want %h", physMem[15'h0042], initWord(32'h42) + 32'd1);
        end
    endtask

    task automatic test_forced_release();
        r0_req = 1;
        r0_we = 0;
        r0_lock = 1;
        r1_req = 1;
        r1_we = 0;
        r1_lock = 0;
        for (int c = 1; c <= 20; c++) begin
            r0_ai = ASZ'(c);
            r1_ai = ASZ'(c + 1000);
            @(negedge clk);
            checks++;
            if (r1_gnt !== (c == 17) || r0_gnt !== (c != 17)) begin
                errors++;
                $display("[TB] FAIL force_gnt[%0d] r0_gnt=%b r1_gnt=%b", c, r0_gnt, r1_gnt);
            end
            advance(expGrant());
            checks++;
            if ({r0_rvld, r1_rvld} !== {pendRd == 0, pendRd == 1} || rd_vo !== pendData) begin
                errors++;
                $display("[TB] FAIL force_rvld[%0d] rvld=%b%b rd_vo=%h want %h", c,
                         r0_rvld, r1_rvld, rd_vo, pendData);
            end
        end
        r1_req = 0;
        r0_lock = 0;
        @(negedge clk);
        advance(expGrant());
        idle();
    endtask

    task automatic test_mid_reset();
        r0_req = 1;
        r0_we = 0;
        r0_ai = 15'h0033;
        r0_lock = 1;
        @(negedge clk);
        checks++;
        if (r0_gnt !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mr_gnt r0_gnt=%b want 1", r0_gnt);
        end
        advance(expGrant());
        r0_we = 1;
        r0_bmsk = 4'hF;
        rst_n = 0;
        modelReset();
        #1;
        checks++;
        if (r0_rvld !== 1'b0 || m_we !== 1'b0 || r0_gnt !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mr_async rvld=%b m_we=%b gnt=%b want 0", r0_rvld, m_we, r0_gnt);
        end
        @(posedge clk);
        #1;
        checks++;
        if (r0_rvld !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mr_held r0_rvld=%b want 0", r0_rvld);
        end
        r0_req = 0;
        r0_we = 0;
        r0_lock = 0;
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        r1_req = 1;
        r1_we = 0;
        r1_ai = 15'h0034;
        @(negedge clk);
        checks++;
        if (r1_gnt !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mr_after r1_gnt=%b want 1", r1_gnt);
        end
        advance(expGrant());
        checks++;
        if (r1_rvld !== 1'b1 || r0_rvld !== 1'b0 || rd_vo !== pendData) begin
            errors++;
            $display("[TB] FAIL mr_read rvld=%b%b rd_vo=%h want 01 %h", r0_rvld, r1_rvld, rd_vo, pendData);
        end
        idle();
    endtask

    task automatic test_random();
        int eg;
        for (int i = 0; i < 400; i++) begin
            r0_req  = ($urandom_range(0, 3) != 0);
            r1_req  = ($urandom_range(0, 3) != 0);
            r0_we   = $urandom_range(0, 1) == 1;
            r1_we   = $urandom_range(0, 1) == 1;
            r0_lock = ($urandom_range(0, 2) != 0);
            r1_lock = ($urandom_range(0, 2) == 0);
            r0_ai   = ASZ'($urandom_range(0, 15));
            r1_ai   = ASZ'($urandom_range(0, 15));
            r0_vi   = $urandom;
            r1_vi   = $urandom;
            r0_bmsk = 4'($urandom_range(0, 15));
            r1_bmsk = 4'($urandom_range(0, 15));
            @(negedge clk);
            eg = expGrant();
            checks++;
            if ({r0_gnt, r1_gnt} !== {eg == 0, eg == 1}) begin
                errors++;
                $display("[TB] FAIL rnd_gnt[%0d] got %b%b want grant %0d", i, r0_gnt, r1_gnt, eg);
            end
            checks++;
            if (eg < 0 && (m_we !== 1'b0 || m_bmsk !== 4'b0 || m_ai !== aiHoldM || m_vi !== viHoldM)) begin
                errors++;
                $display("[TB] FAIL rnd_hold[%0d] we=%b bmsk=%b ai=%h vi=%h want 0 0 %h %h",
                         i, m_we, m_bmsk, m_ai, m_vi, aiHoldM, viHoldM);
            end else if (eg >= 0 && m_ai !== ((eg == 0) ? r0_ai : r1_ai)) begin
                errors++;
                $display("[TB] FAIL rnd_mux[%0d] m_ai=%h wrong for grant %0d", i, m_ai, eg);
            end
            advance(eg);
            checks++;
            if ({r0_rvld, r1_rvld} !== {pendRd == 0, pendRd == 1} ||
                (pendRd >= 0 && rd_vo !== pendData)) begin
                errors++;
                $display("[TB] FAIL rnd_rvld[%0d] rvld=%b%b rd_vo=%h want rd %0d data %h",
                         i, r0_rvld, r1_rvld, rd_vo, pendRd, pendData);
            end
        end
        idle();
    endtask

    initial begin
        for (int a = 0; a < 32768; a++) begin
            physMem[a] = initWord(a);
            refMem[a]  = initWord(a);
        end
        modelReset();
        test_reset();
        test_first_read();
        test_round_robin();
        test_write_top();
        test_locked_rmw();
        test_forced_release();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/mb32_arb.md
Name: mb32_arb

Overview:
- Two-requester arbiter that shares one mb32 single-port 32-bit memory block (128K SPRAM, 15-bit word address, 4-bit byte mask) between requester 0 (instruction fetch) and requester 1 (data/stack access).
- Sits between the eForth core and the memory block. Drives the block's master side: we, bmsk, ai, vi. Returns vo to whichever requester was granted.
- Supports round-robin fairness, a lock for atomic multi-cycle sequences, and a forced release that bounds starvation.

Parameters:
- DSZ, 32, data width (fixed to match the memory bus)
- ASZ, 15, word address width (20 - clog2(DSZ))
- MAX_LOCK, 16, maximum consecutive locked cycles before forced release (range 1..255)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- r0_req / r1_req  in  1  access request, held until granted
- r0_we / r1_we  in  1  1 = write, 0 = read
- r0_ai / r1_ai  in  ASZ  word address
- r0_vi / r1_vi  in  DSZ  write data
- r0_bmsk / r1_bmsk  in  4  byte-lane write mask
- r0_lock / r1_lock  in  1  keep ownership after this access
- r0_gnt / r1_gnt  out  1  request accepted this cycle (combinational)
- r0_rvld / r1_rvld  out  1  read data valid on rd_vo (one cycle after a granted read)
- rd_vo  out  DSZ  read data, passed through from m_vo
- m_we  out  1  memory write enable
- m_ai  out  ASZ  memory address
- m_vi  out  DSZ  memory write data
- m_bmsk  out  4  memory byte mask
- m_vo  in  DSZ  memory read data, valid one cycle after address

Behaviour:
- Reset (async, rst_n=0):
  - state = FREE, last = 1 (so requester 0 wins the first tie), lock_cnt = 0.
  - rN_rvld = 0, rN_gnt = 0.
  - m_we = 0, m_bmsk = 0, m_ai = 0, m_vi = 0.
- States:
  - FREE: no owner.
  - OWN0: requester 0 holds the lock.
  - OWN1: requester 1 holds the lock.
- Grant (combinational from state, req, last):
  - FREE, single requester: grant it.
  - FREE, both requesting: grant the one not equal to last.
  - OWNn: grant only requester n. The other requester's gnt = 0 even if it is requesting.
  - At most one gnt high per cycle.
- Memory mux:
  - Granted requester's we/ai/vi/bmsk drive m_*.
  - No grant: m_we = 0, m_bmsk = 0, m_ai and m_vi hold their previous values (registered mux select).
- Accepted access (req & gnt):
  - Command reaches memory in the same cycle. last <= granted index.
  - If it is a read, the granted rN_rvld = 1 exactly one cycle later and rd_vo = m_vo in that cycle.
  - Writes produce no rvld.
  - Back-to-back reads give one rvld per cycle; rvld always pulses to the requester of the read issued in the previous cycle.
- Lock transitions:
  - FREE -> OWNn on an accepted access with rN_lock=1. lock_cnt <= 1.
  - OWNn, accepted access with lock=1: lock_cnt += 1.
  - OWNn, accepted access with lock=0: -> FREE, lock_cnt <= 0.
  - OWNn, rN_req=0 for a cycle: stay OWNn. The lock persists across idle cycles, and idle cycles also increment lock_cnt.
  - OWNn, lock_cnt reaches MAX_LOCK: forced -> FREE and last <= n, so the other requester wins the next tie.
  - A forced release takes effect in the cycle after the MAX_LOCK-th locked cycle.
- Simultaneous events:
  - Release and a competing request in the same cycle: the competitor is arbitrated from the next cycle.
  - Lock asserted on an access that is not granted: ignored.
- Mid-operation reset: a pending rvld is dropped, the lock is cleared, and m_we is forced low immediately (asynchronously).
- lock_cnt is 8 bits and saturates at MAX_LOCK; it never wraps.

Test Plan:
- Reset -> m_we=0, m_bmsk=0, both gnt=0 with no req. Release rst_n, r0 read of ai=0x0010 -> r0_gnt=1 same cycle, r0_rvld=1 next cycle with rd_vo = memory word 0x0010.
- Both requesters read every cycle for 6 cycles -> grants alternate 0,1,0,1,0,1. Each rvld lands on the correct requester with its data.
- r1 write vi=0xDEADBEEF, bmsk=4'b0011, ai=0x7FFF (top address), then r1 read of 0x7FFF -> rd_vo low 16 bits = 0xBEEF, upper bytes unchanged. r1_rvld asserted for the read only, not the write.
- r0 locked read-modify-write (read with lock=1, one idle cycle, write with lock=0) while r1_req held high -> r1_gnt=0 for all 3 cycles, r1 granted on cycle 4.
- r0 holds lock=1 and requests for 20 cycles with r1 requesting, MAX_LOCK=16 -> forced release after cycle 16, r1_gnt=1 on cycle 17.
- rst_n pulsed low during OWN0 with a read outstanding -> r0_rvld stays 0, state FREE. After release, r1 is granted immediately.
